pipe_score_detect: RTL and testbench

Per-frame collision and scoring detector for the three scrolling pipe obstacles and the player sprite. It sits directly upstream of the game-state controller. Each frame it produces one-frame scoring pulses (`scoring0..2`) and latched game-over levels (`hit0..2`, `ground_hit`), which feed the controller's scoring and game-over inputs. It is active only while the controller's `rdy` is high.

---
 rtl/pipe_score_detect.sv | 163 ++++++++++++++++
 tb/tb_pipe_score_detect.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pipe_score_detect.sv
// pipe_score_detect: per-frame collision and scoring detector for three
// scrolling pipes and the player sprite. There is one small state machine per
// pipe. All outputs are registered on frame_clk. The block is held cleared
// while rdy is low.
module pipe_score_detect #(
    parameter int unsigned PLAYER_X = 160,
    parameter int unsigned PLAYER_W = 16,
    parameter int unsigned PLAYER_H = 16,
    parameter int unsigned PIPE_W   = 40,
    parameter int unsigned GAP_H    = 120,
    parameter int unsigned GROUND_Y = 440
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       rdy,
    input  logic [9:0] player_y,
    input  logic [9:0] obs_x0,
    input  logic [9:0] obs_x1,
    input  logic [9:0] obs_x2,
    input  logic [9:0] gap_y0,
    input  logic [9:0] gap_y1,
    input  logic [9:0] gap_y2,
    output logic       scoring0,
    output logic       scoring1,
    output logic       scoring2,
    output logic       hit0,
    output logic       hit1,
    output logic       hit2,
    output logic       ground_hit,
    output logic [7:0] passes
);

    typedef enum logic [1:0] {
        APPROACH = 2'd0,
        OVERLAP  = 2'd1,
        PASSED   = 2'd2
    } state_t;

    localparam logic [10:0] PLAYER_L = 11'(PLAYER_X);
    localparam logic [10:0] PLAYER_R = 11'(PLAYER_X + PLAYER_W - 1);
    localparam logic [10:0] PIPE_EXT = 11'(PIPE_W - 1);
    localparam logic [10:0] GAP_EXT  = 11'(GAP_H - 1);
    localparam logic [10:0] PLY_EXT  = 11'(PLAYER_H - 1);
    localparam logic [10:0] GROUND   = 11'(GROUND_Y);

    logic [9:0]  obs_x [3];
    logic [9:0]  gap_y [3];
    logic [9:0]  prev_x [3];
    state_t      state [3];
    state_t      state_nxt [3];
    logic [2:0]  hit_q;
    logic [2:0]  hit_nxt;
    logic [2:0]  score_q;
    logic [2:0]  score_nxt;
    logic [2:0]  overlap;
    logic [2:0]  past;
    logic [2:0]  in_gap;
    logic [2:0]  wrap;
    logic        ground_nxt;
    logic [10:0] ply_top;
    logic [10:0] ply_bot;
    logic [1:0]  n_score;

    // Gather the per-pipe inputs into arrays so all three pipes share one description
    always_comb begin
        obs_x[0] = obs_x0;
        obs_x[1] = obs_x1;
        obs_x[2] = obs_x2;
        gap_y[0] = gap_y0;
        gap_y[1] = gap_y1;
        gap_y[2] = gap_y2;
    end

    // Geometry tests in 11-bit zero-extended arithmetic
    always_comb begin
        ply_top = {1'b0, player_y};
        ply_bot = {1'b0, player_y} + PLY_EXT;
        overlap = '0;
        past    = '0;
        in_gap  = '0;
        wrap    = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            overlap[i] = ({1'b0, obs_x[i]} <= PLAYER_R) &&
                         (({1'b0, obs_x[i]} + PIPE_EXT) >= PLAYER_L);
            past[i]    = (({1'b0, obs_x[i]} + PIPE_EXT) < PLAYER_L);
            in_gap[i]  = (ply_top >= {1'b0, gap_y[i]}) &&
                         (ply_bot <= ({1'b0, gap_y[i]} + GAP_EXT));
            wrap[i]    = (obs_x[i] > prev_x[i]);
        end
    end

    // Next-state logic per pipe. A collision is handled before scoring, so a
    // hit pipe never scores.
    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            state_nxt[i] = state[i];
            hit_nxt[i]   = hit_q[i];
            score_nxt[i] = 1'b0;
            case (state[i])
                APPROACH: begin
                    if (overlap[i]) begin
                        state_nxt[i] = OVERLAP;
                        if (!in_gap[i]) hit_nxt[i] = 1'b1;
                    end else if (past[i]) begin
                        // Pipe skipped the overlap window in a single step
                        state_nxt[i] = PASSED;
                        score_nxt[i] = !hit_q[i];
                    end
                end
                OVERLAP: begin
                    if (overlap[i] && !in_gap[i]) begin
                        hit_nxt[i] = 1'b1;
                    end else if (past[i]) begin
                        state_nxt[i] = PASSED;
                        score_nxt[i] = !hit_q[i];
                    end
                end
                PASSED: begin
                    if (wrap[i]) state_nxt[i] = APPROACH;
                end
                default: state_nxt[i] = APPROACH;
            endcase
            if (!rdy) begin
                state_nxt[i] = APPROACH;
                hit_nxt[i]   = 1'b0;
                score_nxt[i] = 1'b0;
            end
        end
        ground_nxt = rdy && (ground_hit || (ply_bot >= GROUND));
        n_score    = {1'b0, score_nxt[0]} + {1'b0, score_nxt[1]} + {1'b0, score_nxt[2]};
    end

    // Register pipe state, flags, pulses and the pass counter
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < 3; i++) begin
                state[i]  <= APPROACH;
                prev_x[i] <= '0;
            end
            hit_q      <= '0;
            score_q    <= '0;
            ground_hit <= 1'b0;
            passes     <= '0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                state[i]  <= state_nxt[i];
                prev_x[i] <= obs_x[i];
            end
            hit_q      <= hit_nxt;
            score_q    <= score_nxt;
            ground_hit <= ground_nxt;
            passes     <= rdy ? (passes + {6'b0, n_score}) : '0;
        end
    end

    assign scoring0 = score_q[0];
    assign scoring1 = score_q[1];
    assign scoring2 = score_q[2];
    assign hit0     = hit_q[0];
    assign hit1     = hit_q[1];
    assign hit2     = hit_q[2];

endmodule

// File: tb/tb_pipe_score_detect.sv
// Directed bench for pipe_score_detect: clean pass, respawn, ground boundary,
// rdy clear, collision, asynchronous reset mid-overlap, and a simultaneous
// triple pass that wraps the pass counter.
module tb_pipe_score_detect;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic       rdy;
    logic [9:0] player_y;
    logic [9:0] obs_x0, obs_x1, obs_x2;
    logic [9:0] gap_y0, gap_y1, gap_y2;
    logic       scoring0, scoring1, scoring2;
    logic       hit0, hit1, hit2;
    logic       ground_hit;
    logic [7:0] passes;

    int total = 0;
    int bad   = 0;
    int pulses;

    pipe_score_detect #(
        .PLAYER_X(160), .PLAYER_W(16), .PLAYER_H(16),
        .PIPE_W(40), .GAP_H(120), .GROUND_Y(440)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .rdy       (rdy),
        .player_y  (player_y),
        .obs_x0    (obs_x0),
        .obs_x1    (obs_x1),
        .obs_x2    (obs_x2),
        .gap_y0    (gap_y0),
        .gap_y1    (gap_y1),
        .gap_y2    (gap_y2),
        .scoring0  (scoring0),
        .scoring1  (scoring1),
        .scoring2  (scoring2),
        .hit0      (hit0),
        .hit1      (hit1),
        .hit2      (hit2),
        .ground_hit(ground_hit),
        .passes    (passes)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Advance one frame; outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, {23'b0, scoring0, scoring1, scoring2, hit0, hit1, hit2, ground_hit, 2'b0}, 32'd0);
        chk({tag, "_passes"}, {24'b0, passes}, 32'd0);
    endtask

    initial begin
        Reset = 1'b1; rdy = 1'b0; player_y = 10'd200;
        obs_x0 = 10'd300; obs_x1 = 10'd600; obs_x2 = 10'd600;
        gap_y0 = 10'd150; gap_y1 = 10'd150; gap_y2 = 10'd150;
        #2;
        chk_all_zero("reset");
        tick();
        Reset = 1'b0; rdy = 1'b1;

        // Clean pass: pulse in the frame after obs_x0=120 is sampled
        pulses = 0;
        for (int x = 300; x >= 0; x -= 2) begin
            obs_x0 = 10'(x);
            tick();
            chk("clean_score0", {31'b0, scoring0}, {31'b0, (x == 120)});
            chk("clean_hit0", {31'b0, hit0}, 32'd0);
            if (scoring0) pulses++;
        end
        chk("clean_pulses", pulses, 32'd1);
        chk("clean_passes", {24'b0, passes}, 32'd1);

        // Respawn from 0 to 640 and scroll again
        for (int x = 640; x >= 0; x -= 2) begin
            obs_x0 = 10'(x);
            tick();
            chk("respawn_score0", {31'b0, scoring0}, {31'b0, (x == 120)});
        end
        chk("respawn_passes", {24'b0, passes}, 32'd2);

        // Ground boundary: 424+15=439 is clear, 425+15=440 touches
        player_y = 10'd424; tick();
        chk("ground_424", {31'b0, ground_hit}, 32'd0);
        player_y = 10'd425; tick();
        chk("ground_425", {31'b0, ground_hit}, 32'd1);
        player_y = 10'd200; tick();
        chk("ground_sticky", {31'b0, ground_hit}, 32'd1);

        // rdy low for one frame clears everything
        rdy = 1'b0; tick();
        chk_all_zero("rdy_clear1");
        rdy = 1'b1;

        // Collision: player above the gap
        player_y = 10'd100;
        for (int x = 300; x >= 0; x -= 2) begin
            obs_x0 = 10'(x);
            tick();
            chk("coll_hit0", {31'b0, hit0}, {31'b0, (x <= 174)});
            chk("coll_score0", {31'b0, scoring0}, 32'd0);
        end
        chk("coll_passes", {24'b0, passes}, 32'd0);

        // Bring pipe0 back into overlap, then reset between edges
        obs_x0 = 10'd170; tick();
        tick();
        chk("pre_reset_hit0", {31'b0, hit0}, 32'd1);
        #3;
        Reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        tick();
        Reset = 1'b0;

        // Score by skipping, then a hit, then drop rdy for one frame
        obs_x0 = 10'd100; tick();
        chk("skip_score0", {31'b0, scoring0}, 32'd1);
        chk("skip_passes", {24'b0, passes}, 32'd1);
        obs_x0 = 10'd300; tick();
        chk("skip_no_repeat", {31'b0, scoring0}, 32'd0);
        obs_x0 = 10'd170; tick();
        chk("hit_before_drop", {31'b0, hit0}, 32'd1);
        chk("passes_before_drop", {24'b0, passes}, 32'd1);
        rdy = 1'b0; tick();
        chk("drop_hit0", {31'b0, hit0}, 32'd0);
        chk("drop_passes", {24'b0, passes}, 32'd0);
        rdy = 1'b1;

        // Ramp passes to 254 by alternating skip and respawn on pipe0
        player_y = 10'd200;
        obs_x0 = 10'd500; tick();
        for (int n = 0; n < 254; n++) begin
            obs_x0 = 10'd100; tick();
            chk("ramp_score", {31'b0, scoring0}, 32'd1);
            obs_x0 = 10'd500; tick();
            chk("ramp_idle", {31'b0, scoring0}, 32'd0);
        end
        chk("ramp_passes", {24'b0, passes}, 32'd254);

        // Three pipes in lockstep: simultaneous pulses, counter wraps to 1
        for (int x = 300; x >= 100; x -= 2) begin
            obs_x0 = 10'(x); obs_x1 = 10'(x); obs_x2 = 10'(x);
            tick();
            chk("sim_score0", {31'b0, scoring0}, {31'b0, (x == 120)});
            chk("sim_score1", {31'b0, scoring1}, {31'b0, (x == 120)});
            chk("sim_score2", {31'b0, scoring2}, {31'b0, (x == 120)});
            if (x == 122) chk("sim_passes_pre", {24'b0, passes}, 32'd254);
            if (x == 120) chk("sim_passes_wrap", {24'b0, passes}, 32'd1);
        end
        chk("sim_hits", {29'b0, hit0, hit1, hit2}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
